// File: rtl/sync_fifo_adv_if.sv
// Producer/consumer bundle for sync_fifo_adv: write side, read side, flush and status.
interface sync_fifo_adv_if #(
  parameter int F_WIDTH = 32,
  parameter int CNT_W   = 5
);
  logic               clr;
  logic               wr_en;
  logic [F_WIDTH-1:0] wr_data;
  logic               rd_en;
  logic [F_WIDTH-1:0] rd_data;
  logic               rd_valid;
  logic               full;
  logic               empty;
  logic               almost_full;
  logic               almost_empty;
  logic [CNT_W-1:0]   count;
  logic               overflow;
  logic               underflow;

  modport master (
    output clr, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clr, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_adv.sv
// Single-clock FIFO with arbitrary depth, occupancy count, almost flags, sticky
// error flags, synchronous flush and a build-time registered/FWFT read port.
module sync_fifo_adv #(
  parameter int F_WIDTH  = 32,
  parameter int F_DEPTH  = 16,
  parameter int FWFT     = 0,
  parameter int AF_LEVEL = 12,
  parameter int AE_LEVEL = 4,
  parameter int CNT_W    = $clog2(F_DEPTH + 1),
  parameter int P_N      = $clog2(F_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  sync_fifo_adv_if.slave  bus
);

  logic [F_WIDTH-1:0] mem [F_DEPTH];
  logic [P_N-1:0]     wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_eff;
  logic               full_q, empty_q, af_q, ae_q, ovf_q, udf_q;
  logic               wr_acc, rd_acc;

  // Wrap explicitly at F_DEPTH-1 so non-power-of-2 depths never index past the array.
  function automatic logic [P_N-1:0] ptr_inc(input logic [P_N-1:0] p);
    return (p == P_N'(F_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign wr_acc = bus.wr_en & ~full_q  & ~bus.clr;
  assign rd_acc = bus.rd_en & ~empty_q & ~bus.clr;

  always_comb begin
    cnt_nxt = cnt;
    if (wr_acc && !rd_acc)      cnt_nxt = cnt + 1'b1;
    else if (rd_acc && !wr_acc) cnt_nxt = cnt - 1'b1;
    cnt_eff = bus.clr ? '0 : cnt_nxt;
  end

  // Stage p0: pointers, occupancy and flags, all derived from the next count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      cnt     <= cnt_eff;
      full_q  <= (cnt_eff == CNT_W'(F_DEPTH));
      empty_q <= (cnt_eff == '0);
      af_q    <= (cnt_eff >= CNT_W'(AF_LEVEL));
      ae_q    <= (cnt_eff <= CNT_W'(AE_LEVEL));
      if (bus.clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        ovf_q  <= 1'b0;
        udf_q  <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
        if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
        if (bus.wr_en && full_q)  ovf_q <= 1'b1;
        if (bus.rd_en && empty_q) udf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= bus.wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rd_data  = mem[rd_ptr];
      assign bus.rd_valid = ~empty_q;
    end else begin : g_std
      logic [F_WIDTH-1:0] rd_data_p1;
      logic               vld_p1;

      // Stage p1: registered read, valid for exactly the cycle after a pop.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_p1 <= '0;
          vld_p1     <= 1'b0;
        end else begin
          vld_p1 <= rd_acc;
          if (rd_acc) rd_data_p1 <= mem[rd_ptr];
        end
      end

      assign bus.rd_data  = rd_data_p1;
      assign bus.rd_valid = vld_p1;
    end
  endgenerate

  assign bus.count        = cnt;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_adv.sv
// Directed bench: depth-16 standard, depth-12 standard (wrap) and depth-4 FWFT instances.
module tb_sync_fifo_adv;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sync_fifo_adv_if #(.F_WIDTH(8), .CNT_W(5)) b0 ();
  sync_fifo_adv_if #(.F_WIDTH(8), .CNT_W(4)) b1 ();
  sync_fifo_adv_if #(.F_WIDTH(8), .CNT_W(3)) b2 ();

  sync_fifo_adv #(.F_WIDTH(8), .F_DEPTH(16), .FWFT(0), .AF_LEVEL(12), .AE_LEVEL(4))
    u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  sync_fifo_adv #(.F_WIDTH(8), .F_DEPTH(12), .FWFT(0), .AF_LEVEL(10), .AE_LEVEL(2))
    u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  sync_fifo_adv #(.F_WIDTH(8), .F_DEPTH(4), .FWFT(1), .AF_LEVEL(3), .AE_LEVEL(1))
    u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    b0.clr = 0; b0.wr_en = 0; b0.rd_en = 0; b0.wr_data = '0;
    b1.clr = 0; b1.wr_en = 0; b1.rd_en = 0; b1.wr_data = '0;
    b2.clr = 0; b2.wr_en = 0; b2.rd_en = 0; b2.wr_data = '0;
    tick(); tick();

    check("rst_count",  32'(b0.count), 0);
    check("rst_empty",  32'(b0.empty), 1);
    check("rst_full",   32'(b0.full), 0);
    check("rst_ae",     32'(b0.almost_empty), 1);
    check("rst_af",     32'(b0.almost_full), 0);
    check("rst_ovf",    32'(b0.overflow), 0);
    check("rst_udf",    32'(b0.underflow), 0);
    check("rst_rvalid", 32'(b0.rd_valid), 0);
    check("rst_rdata",  32'(b0.rd_data), 0);
    rst_n = 1'b1;

    // Fill depth-16 with 0..15
    for (int i = 0; i < 16; i++) begin
      b0.wr_en = 1; b0.wr_data = 8'(i);
      tick();
      check("fill_count", 32'(b0.count), 32'(i + 1));
      check("fill_af",    32'(b0.almost_full), 32'((i + 1) >= 12));
    end
    b0.wr_en = 0;
    check("full_set", 32'(b0.full), 1);
    check("full_nempty", 32'(b0.empty), 0);

    // Write while full
    b0.wr_en = 1; b0.wr_data = 8'hFF;
    tick();
    b0.wr_en = 0;
    check("ovf_set",   32'(b0.overflow), 1);
    check("ovf_count", 32'(b0.count), 16);
    check("ovf_full",  32'(b0.full), 1);

    // Read+write while full: only the read is accepted
    b0.wr_en = 1; b0.rd_en = 1; b0.wr_data = 8'hEE;
    tick();
    b0.wr_en = 0;
    check("sim_full_count", 32'(b0.count), 15);
    check("sim_full_rv",    32'(b0.rd_valid), 1);
    check("sim_full_data",  32'(b0.rd_data), 0);
    check("sim_full_full",  32'(b0.full), 0);

    for (int i = 1; i < 16; i++) begin
      tick();
      check("drain_data", 32'(b0.rd_data), 32'(i));
      check("drain_rv",   32'(b0.rd_valid), 1);
      check("drain_ae",   32'(b0.almost_empty), 32'((15 - i) <= 4));
      check("drain_af",   32'(b0.almost_full), 32'((15 - i) >= 12));
    end
    check("drain_empty", 32'(b0.empty), 1);
    check("drain_count", 32'(b0.count), 0);

    // Read while empty
    tick();
    b0.rd_en = 0;
    check("udf_set",   32'(b0.underflow), 1);
    check("udf_rv",    32'(b0.rd_valid), 0);
    check("udf_hold",  32'(b0.rd_data), 15);
    check("udf_ovf",   32'(b0.overflow), 1);

    b0.clr = 1;
    tick();
    b0.clr = 0;
    check("clr_ovf", 32'(b0.overflow), 0);
    check("clr_udf", 32'(b0.underflow), 0);

    // Simultaneous at count 5
    for (int i = 0; i < 5; i++) begin
      b0.wr_en = 1; b0.wr_data = 8'(8'h10 + i);
      tick();
    end
    b0.rd_en = 1; b0.wr_data = 8'h15;
    tick();
    b0.wr_en = 0;
    check("sim5_count", 32'(b0.count), 5);
    check("sim5_data",  32'(b0.rd_data), 32'h10);
    for (int i = 1; i < 6; i++) begin
      tick();
      check("sim5_order", 32'(b0.rd_data), 32'(8'h10 + i));
    end
    b0.rd_en = 0;
    check("sim5_empty", 32'(b0.empty), 1);

    // Simultaneous at count 0: write only, no bypass
    b0.wr_en = 1; b0.rd_en = 1; b0.wr_data = 8'h30;
    tick();
    b0.rd_en = 0;
    check("sim0_count", 32'(b0.count), 1);
    check("sim0_rv",    32'(b0.rd_valid), 0);
    check("sim0_udf",   32'(b0.underflow), 1);
    for (int i = 1; i < 7; i++) begin
      b0.wr_data = 8'(8'h30 + i);
      tick();
    end
    check("pre_clr_count", 32'(b0.count), 7);

    // clr beats wr_en
    b0.clr = 1; b0.wr_data = 8'h99;
    tick();
    b0.clr = 0; b0.wr_en = 0;
    check("clrw_count", 32'(b0.count), 0);
    check("clrw_empty", 32'(b0.empty), 1);
    check("clrw_ae",    32'(b0.almost_empty), 1);
    check("clrw_udf",   32'(b0.underflow), 0);
    check("clrw_rdata", 32'(b0.rd_data), 32'h15);
    check("clrw_rv",    32'(b0.rd_valid), 0);

    // Depth-12 wrap: prefill 5, 40 simultaneous pairs, drain
    for (int i = 0; i < 5; i++) begin
      b1.wr_en = 1; b1.wr_data = 8'(i);
      tick();
    end
    b1.rd_en = 1;
    for (int k = 0; k < 40; k++) begin
      b1.wr_data = 8'(5 + k);
      tick();
      check("wrap_data",  32'(b1.rd_data), 32'(k));
      check("wrap_count", 32'(b1.count), 5);
    end
    b1.wr_en = 0;
    for (int k = 40; k < 45; k++) begin
      tick();
      check("wrap_drain", 32'(b1.rd_data), 32'(k));
    end
    b1.rd_en = 0;
    check("wrap_empty", 32'(b1.empty), 1);
    for (int i = 0; i < 12; i++) begin
      b1.wr_en = 1; b1.wr_data = 8'(100 + i);
      tick();
    end
    b1.wr_data = 8'hAA;
    tick();
    b1.wr_en = 0;
    check("d12_full",  32'(b1.full), 1);
    check("d12_count", 32'(b1.count), 12);
    check("d12_ovf",   32'(b1.overflow), 1);
    b1.rd_en = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("d12_data", 32'(b1.rd_data), 32'(100 + i));
    end
    b1.rd_en = 0;
    check("d12_empty", 32'(b1.empty), 1);

    // FWFT
    check("fwft_rst_rv", 32'(b2.rd_valid), 0);
    b2.wr_en = 1; b2.wr_data = 8'hA5;
    tick();
    check("fwft_rv",   32'(b2.rd_valid), 1);
    check("fwft_data", 32'(b2.rd_data), 32'hA5);
    b2.wr_data = 8'hB6;
    tick();
    b2.wr_en = 0;
    check("fwft_head",  32'(b2.rd_data), 32'hA5);
    check("fwft_count", 32'(b2.count), 2);
    b2.rd_en = 1;
    tick();
    check("fwft_next", 32'(b2.rd_data), 32'hB6);
    check("fwft_cnt1", 32'(b2.count), 1);
    tick();
    b2.rd_en = 0;
    check("fwft_empty", 32'(b2.empty), 1);
    check("fwft_rv0",   32'(b2.rd_valid), 0);

    // Async reset mid-burst
    b0.wr_en = 1; b0.wr_data = 8'h40;
    tick();
    b0.wr_data = 8'h41;
    tick();
    check("burst_count", 32'(b0.count), 2);
    b0.wr_data = 8'h42;
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(b0.count), 0);
    check("arst_empty", 32'(b0.empty), 1);
    check("arst_ae",    32'(b0.almost_empty), 1);
    check("arst_rdata", 32'(b0.rd_data), 0);
    check("arst_rv",    32'(b0.rd_valid), 0);
    b0.wr_en = 0;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_count", 32'(b0.count), 0);
    b0.wr_en = 1; b0.wr_data = 8'h50;
    tick();
    b0.wr_en = 0; b0.rd_en = 1;
    tick();
    b0.rd_en = 0;
    check("resume_data", 32'(b0.rd_data), 32'h50);
    check("resume_rv",   32'(b0.rd_valid), 1);
    check("resume_cnt",  32'(b0.count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_fifo_adv.md
Name: sync_fifo_adv

Overview:
Parametrised single-clock FIFO and the successor to the basic sync FIFO. It adds:
- non-power-of-2 depth;
- an occupancy count;
- programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags;
- a synchronous flush;
- a compile-time choice between standard (registered-read) and first-word-fall-through (FWFT) output mode.

It sits between producer and consumer pipeline stages in the same clock domain.

Parameters:
- F_WIDTH, 32: data width in bits; must be ≥1.
- F_DEPTH, 16: number of entries; must be ≥2; need not be a power of 2.
- FWFT, 0: output mode. 0 = standard registered read; 1 = first-word-fall-through.
- AF_LEVEL, 12: almost_full asserts when count ≥ AF_LEVEL. Legal range 1..F_DEPTH.
- AE_LEVEL, 4: almost_empty asserts when count ≤ AE_LEVEL. Legal range 0..F_DEPTH-1.
- CNT_W, $clog2(F_DEPTH+1): width of count.
- P_N, $clog2(F_DEPTH): pointer width.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush, active high.
- wr_en  input  1  write request.
- wr_data  input  F_WIDTH  write data.
- rd_en  input  1  read request (pop).
- rd_data  output  F_WIDTH  read data.
- rd_valid  output  1  rd_data holds valid data.
- full  output  1  count == F_DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count ≥ AF_LEVEL.
- almost_empty  output  1  count ≤ AE_LEVEL.
- count  output  CNT_W  current occupancy, 0..F_DEPTH.
- overflow  output  1  sticky: a write was attempted while full.
- underflow  output  1  sticky: a read was attempted while empty.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0, rd_valid=0, rd_data=0 (standard mode). Memory array is not reset.
- Accept rules:
  - wr_acc = wr_en & ~full & ~clr.
  - rd_acc = rd_en & ~empty & ~clr.
- Simultaneous read and write:
  - When both are accepted, count is unchanged and both pointers advance.
  - When full, only the read is accepted: count decreases by 1 and full deasserts next cycle.
  - When empty, only the write is accepted: count increases by 1. There is no bypass in either mode.
- Pointer wrap: a pointer at F_DEPTH-1 advances to 0 on accept. A pointer holds when its side does not accept. This must work for non-power-of-2 depth (e.g. 12).
- Count update: count_nxt = count + wr_acc - rd_acc.
- Flags: full, empty, almost_full and almost_empty are registered, computed from count_nxt. They are therefore coherent with count in every cycle.
- Write: on wr_acc, mem[wr_ptr] is written with wr_data.
- Standard mode (FWFT=0):
  - rd_acc at cycle N: rd_data = mem[rd_ptr] at N+1, with rd_valid=1 for exactly that cycle.
  - rd_data holds its value when there is no accept. rd_valid=0 otherwise.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] combinationally; rd_valid = ~empty.
  - rd_en pops the head. The next entry appears in the cycle after rd_acc.
  - A word written into an empty FIFO appears on rd_data one cycle after wr_acc, when empty falls.
- Error flags:
  - overflow sets on wr_en & full; underflow sets on rd_en & empty.
  - Both are sticky until clr or rst_n.
  - The rejected operation has no other effect.
- clr (synchronous flush):
  - Next cycle: pointers=0, count=0, empty=1, full=0, almost flags per count=0, overflow=0, underflow=0, rd_valid=0.
  - clr overrides a simultaneous wr_en or rd_en: no accept, and no error flag set.
  - rd_data and memory contents are unchanged.
- Reset mid-operation: asserting rst_n low forces the reset values immediately, independent of clk. Operation resumes on the first edge after deassertion.

Test Plan:
1. Fill/drain (F_DEPTH=16): write 0..15 on consecutive cycles → full=1 at cycle after the 16th write, count=16, almost_full set when count reaches 12. Read 16 times → data 0..15 in order, empty=1, almost_empty set when count reaches 4.
2. Overflow/underflow: a 17th write while full → overflow=1, count stays 16, mem unchanged. Drain, then rd_en while empty → underflow=1. Pulse clr → both flags 0.
3. Simultaneous: at count=16, wr_en & rd_en → count=15, only the read is accepted. At count=5, both → count=5 and order preserved. At count=0, both → count=1, rd_valid=0.
4. Wrap with F_DEPTH=12: 40 interleaved write/read pairs of an incrementing pattern → every read matches, pointers wrap 11→0, count never exceeds 12.
5. FWFT=1: write 0xA5 into empty → rd_valid=1 and rd_data=0xA5 next cycle, with no rd_en. Pop → empty=1.
6. clr with wr_en=1 at count=7 → count=0, empty=1, no write accepted. Async rst_n low mid-burst → all outputs at reset values immediately.
